// File: rtl/pkg_opengpu.sv
// Shared OpenGPU datapath widths and the FPU writeback queue entry.
package pkg_opengpu;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned FPU_RD_W   = 5;

   // One queued FPU result: payload, destination index and register-file select
   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [FPU_RD_W-1:0]   rd;
      logic                  fp_dst;
   } fpu_wb_entry_t;

endpackage

// File: rtl/fpu_wb_queue_if.sv
// Handshake bundle between the FPU, the writeback queue and the register-file writeback port.
interface fpu_wb_queue_if #(
   parameter int unsigned REG_ADDR_W = 5
);
   import pkg_opengpu::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_result;
   logic [REG_ADDR_W-1:0] in_rd;
   logic                  in_fp_dst;

   logic                  wb_valid;
   logic                  wb_ready;
   logic [DATA_WIDTH-1:0] wb_result;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_fp_dst;

   // Surrounding pipeline: produces FPU results and consumes writebacks
   modport master (
      output in_valid, in_result, in_rd, in_fp_dst, wb_ready,
      input  in_ready, wb_valid, wb_result, wb_rd, wb_fp_dst
   );

   // The queue itself
   modport slave (
      input  in_valid, in_result, in_rd, in_fp_dst, wb_ready,
      output in_ready, wb_valid, wb_result, wb_rd, wb_fp_dst
   );

endinterface

// File: rtl/fpu_wb_queue.sv
// In-order FIFO of FPU results awaiting register-file writeback; no bypass, flush discards all.
module fpu_wb_queue
   import pkg_opengpu::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   fpu_wb_queue_if.slave          wbq,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fpu_wb_entry_t        mem [DEPTH];
   fpu_wb_entry_t        wr_entry;
   fpu_wb_entry_t        head;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 push;
   logic                 pop;

   // Handshakes; flush blocks acceptance and cancels any same-cycle retire
   assign wbq.in_ready = !rst && (count != CNT_W'(DEPTH)) && !flush;
   assign wbq.wb_valid = (count != '0);
   assign push         = wbq.in_valid && wbq.in_ready;
   assign pop          = wbq.wb_valid && wbq.wb_ready && !flush;

   assign wr_entry.result = wbq.in_result;
   assign wr_entry.rd     = FPU_RD_W'(wbq.in_rd);
   assign wr_entry.fp_dst = wbq.in_fp_dst;

   assign head          = mem[rd_ptr];
   assign wbq.wb_result = head.result;
   assign wbq.wb_rd     = REG_ADDR_W'(head.rd);
   assign wbq.wb_fp_dst = head.fp_dst;

   // Entry storage is deliberately left unreset; contents are meaningless while empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= PTR_W'(wr_ptr + 1'b1);
         end
         if (pop) begin
            rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         end
         case ({push, pop})
            2'b10:   count <= CNT_W'(count + 1'b1);
            2'b01:   count <= CNT_W'(count - 1'b1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/fpu_wb_queue.md
FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; power of two, minimum 2.
REQ-002 Parameter: REG_ADDR_W, 5, width of the destination register index.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  an FPU result is presented.
REQ-006 Port: in_ready  output  1  the queue can accept an entry this cycle.
REQ-007 Port: in_result  input  DATA_WIDTH  FPU result, e.g. an FCVTWS/FCVTSW output.
REQ-008 Port: in_rd  input  REG_ADDR_W  destination register index.
REQ-009 Port: in_fp_dst  input  1  1 = FP register file, 0 = integer register file (FCVTWS writes integer).
REQ-010 Port: flush  input  1  discard all queued entries.
REQ-011 Port: wb_valid  output  1  the head entry is valid for writeback.
REQ-012 Port: wb_ready  input  1  the writeback port accepts the head entry.
REQ-013 Port: wb_result  output  DATA_WIDTH  head entry result.
REQ-014 Port: wb_rd  output  REG_ADDR_W  head entry destination.
REQ-015 Port: wb_fp_dst  output  1  head entry register-file select.
REQ-016 Port: count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Push occurs when in_valid && in_ready at a rising edge; pop occurs when wb_valid && wb_ready at a rising edge.
REQ-018 in_ready SHALL be (count != DEPTH) && !flush, combinationally; it does not depend on wb_ready.
REQ-019 wb_valid SHALL be (count != 0); wb_result, wb_rd and wb_fp_dst are driven from the head entry storage.
REQ-020 There is no bypass: an entry pushed at edge N is visible on wb_* from edge N onward, i.e. a minimum latency of 1 cycle.
REQ-021 Ordering SHALL be strict FIFO; entries retire in push order.
REQ-022 wb_* SHALL hold stable while wb_valid && !wb_ready.
REQ-023 A simultaneous push and pop when 0 < count < DEPTH leaves count unchanged and advances both pointers.
REQ-024 When full, in_ready is 0, so a pop that cycle frees a slot and in_ready returns to 1 the next cycle.
REQ-025 When empty, wb_valid is 0 and wb_ready is ignored; count never underflows.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-027 flush at an edge SHALL zero count and both pointers; a push or pop in the same cycle is discarded, and wb_valid is 0 the following cycle.
REQ-028 Data fields SHALL pass through bit-exact with no modification of result encoding.
REQ-029 count SHALL equal pushes minus pops since the last reset or flush, saturating at neither bound because the handshake rules prevent overflow.

Reset
REQ-030 On rst assertion, asynchronously: count=0, pointers=0, wb_valid=0, and in_ready=0 while rst is high.
REQ-031 Entry storage SHALL NOT be reset; wb_result, wb_rd and wb_fp_dst are don't-care while wb_valid=0.
REQ-032 After rst is released mid-operation, all prior entries are lost and the first push after release appears as the head.

Structure
REQ-033 DATA_WIDTH SHALL come from pkg_opengpu.
REQ-034 An fpu_wb_entry_t packed struct {result, rd, fp_dst} SHALL be added to pkg_opengpu.
REQ-035 The module is a single flat block with no sub-modules; storage is an array of fpu_wb_entry_t.

Verification
REQ-036 After reset, push 0x7FFFFFFF to rd=3 (int) then 0x4F000000 to rd=7 (fp) with wb_ready=1 -> wb shows rd3/0x7FFFFFFF then rd7/0x4F000000 on consecutive cycles; count returns to 0.
REQ-037 With wb_ready=0, push 5 entries back-to-back -> the first 4 are accepted, in_ready=0 from the cycle count=4, and the 5th is held upstream.
REQ-038 At count=2, push and pop in the same cycle -> count stays 2 and the order is preserved.
REQ-039 At count=3, assert flush together with in_valid and wb_ready -> count=0 and wb_valid=0 next cycle; the pushed entry never appears.
REQ-040 Run 20 push/pop cycles to cross the pointer wrap twice with randomized wb_ready stalls -> output sequence equals input sequence and wb_* are stable during every stall.
REQ-041 Assert rst mid-stream at count=2 -> wb_valid and count drop immediately without waiting for a clock edge.
